// File: rtl/atm_multi_account.sv
// atm_multi_account: multi-account ATM controller with per-account password and balance files.
// Emits binary status only; display encoding happens downstream.
module atm_multi_account #(
   parameter  int unsigned N_ACCOUNTS = 4,
   parameter  int unsigned SW_W       = 4,
   parameter  int unsigned BAL_W      = 8,
   parameter  int unsigned MAX_TRIES  = 3,
   parameter  int unsigned LONG_LOCK  = 80,
   parameter  int unsigned SHORT_LOCK = 40,
   localparam int unsigned ACCT_W     = (N_ACCOUNTS > 1) ? $clog2(N_ACCOUNTS) : 1,
   localparam int unsigned TRY_W      = $clog2(MAX_TRIES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              BTN3,
   input  logic              BTN2,
   input  logic              BTN1,
   input  logic [SW_W-1:0]   SW,
   output logic [2:0]        state_o,
   output logic [ACCT_W-1:0] acct_o,
   output logic [BAL_W-1:0]  balance_o,
   output logic [TRY_W-1:0]  tries_o,
   output logic              locked_o,
   output logic              err_o
);

   localparam int unsigned MAX_LOCK = (LONG_LOCK > SHORT_LOCK) ? LONG_LOCK : SHORT_LOCK;
   localparam int unsigned TMR_W    = $clog2(MAX_LOCK + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PW_ENTRY = 3'd1,
      S_MENU     = 3'd2,
      S_MONEY    = 3'd3,
      S_PW_OLD   = 3'd4,
      S_PW_NEW   = 3'd5,
      S_LOCK     = 3'd6
   } state_t;

   state_t             r_state;
   state_t             r_exit;
   logic [ACCT_W-1:0]  r_acct;
   logic [SW_W-1:0]    r_pw  [N_ACCOUNTS];
   logic [BAL_W-1:0]   r_bal [N_ACCOUNTS];
   logic [BAL_W-1:0]   r_balance;
   logic [TRY_W-1:0]   r_tries;
   logic [TMR_W-1:0]   r_timer;
   logic               r_locked;
   logic               r_err;

   // Only single-button cycles count as a press.
   logic               w_b3, w_b2, w_b1;
   logic [ACCT_W-1:0]  w_idx;
   logic               w_idx_ok;
   logic [BAL_W-1:0]   w_sel_bal;
   logic [BAL_W:0]     w_sum;
   logic [BAL_W-1:0]   w_amt;
   logic [BAL_W-1:0]   w_diff;
   logic               w_pw_ok;
   logic               w_last_try;

   assign w_b3       = BTN3 & ~BTN2 & ~BTN1;
   assign w_b2       = BTN2 & ~BTN3 & ~BTN1;
   assign w_b1       = BTN1 & ~BTN3 & ~BTN2;
   assign w_idx      = SW[ACCT_W-1:0];
   assign w_idx_ok   = 32'(SW) < N_ACCOUNTS;
   assign w_sel_bal  = r_bal[r_acct];
   assign w_sum      = {1'b0, w_sel_bal} + (BAL_W+1)'(SW);
   assign w_amt      = BAL_W'(SW);
   assign w_diff     = w_sel_bal - w_amt;
   assign w_pw_ok    = (SW == r_pw[r_acct]);
   assign w_last_try = (r_tries == TRY_W'(MAX_TRIES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_exit    <= S_IDLE;
         r_acct    <= '0;
         r_balance <= '0;
         r_tries   <= '0;
         r_timer   <= '0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
         for (int unsigned i = 0; i < N_ACCOUNTS; i++) begin
            r_pw[i]  <= '0;
            r_bal[i] <= '0;
         end
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_b3) begin
                  if (w_idx_ok) begin
                     r_acct    <= w_idx;
                     r_balance <= r_bal[w_idx];
                     r_tries   <= '0;
                     r_state   <= S_PW_ENTRY;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_PW_ENTRY, S_PW_OLD: begin
               if (w_b3) begin
                  if (w_pw_ok) begin
                     r_tries <= '0;
                     r_state <= (r_state == S_PW_ENTRY) ? S_MENU : S_PW_NEW;
                  end else if (w_last_try) begin
                     r_tries  <= '0;
                     r_timer  <= TMR_W'(LONG_LOCK);
                     r_locked <= 1'b1;
                     r_exit   <= S_IDLE;
                     r_state  <= S_LOCK;
                  end else begin
                     r_tries <= r_tries + 1'b1;
                  end
               end else if (w_b1) begin
                  r_state <= (r_state == S_PW_ENTRY) ? S_IDLE : S_MENU;
               end
            end
            S_MENU: begin
               if (w_b3) begin
                  r_state <= S_MONEY;
               end else if (w_b2) begin
                  r_tries <= '0;
                  r_state <= S_PW_OLD;
               end else if (w_b1) begin
                  r_state <= S_IDLE;
               end
            end
            S_MONEY: begin
               if (w_b3) begin
                  if (w_sum[BAL_W]) begin
                     r_err <= 1'b1;
                  end else begin
                     r_bal[r_acct] <= w_sum[BAL_W-1:0];
                     r_balance     <= w_sum[BAL_W-1:0];
                  end
               end else if (w_b2) begin
                  if (w_amt <= w_sel_bal) begin
                     r_bal[r_acct] <= w_diff;
                     r_balance     <= w_diff;
                  end else begin
                     // Overdraw attempt: short lock, then back to the money screen.
                     r_err    <= 1'b1;
                     r_timer  <= TMR_W'(SHORT_LOCK);
                     r_locked <= 1'b1;
                     r_exit   <= S_MONEY;
                     r_state  <= S_LOCK;
                  end
               end else if (w_b1) begin
                  r_state <= S_MENU;
               end
            end
            S_PW_NEW: begin
               if (w_b3) begin
                  r_pw[r_acct] <= SW;
                  r_state      <= S_MENU;
               end else if (w_b1) begin
                  r_state <= S_MENU;
               end
            end
            S_LOCK: begin
               // Timer was loaded with N on entry, so this leaves after exactly N locked cycles.
               if (r_timer <= TMR_W'(1)) begin
                  r_timer  <= '0;
                  r_locked <= 1'b0;
                  r_state  <= r_exit;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign state_o   = r_state;
   assign acct_o    = r_acct;
   assign balance_o = r_balance;
   assign tries_o   = r_tries;
   assign locked_o  = r_locked;
   assign err_o     = r_err;

endmodule

// File: tb/tb_atm_multi_account.sv
// tb_atm_multi_account: directed plus random stimulus, cycle-by-cycle scoreboard against an
// account-level behavioural model of the ATM.
module tb_atm_multi_account;

   localparam int unsigned N_ACC      = 4;
   localparam int unsigned MAX_TRIES  = 3;
   localparam int unsigned LONG_LOCK  = 80;
   localparam int unsigned SHORT_LOCK = 40;
   localparam int unsigned BAL_MAX    = 255;

   localparam int ST_IDLE = 0, ST_PW_ENTRY = 1, ST_MENU = 2, ST_MONEY = 3;
   localparam int ST_PW_OLD = 4, ST_PW_NEW = 5, ST_LOCK = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       BTN3, BTN2, BTN1;
   logic [3:0] SW;
   logic [2:0] state_o;
   logic [1:0] acct_o;
   logic [7:0] balance_o;
   logic [1:0] tries_o;
   logic       locked_o;
   logic       err_o;

   always #5 clk = ~clk;

   atm_multi_account #(
      .N_ACCOUNTS(N_ACC), .SW_W(4), .BAL_W(8), .MAX_TRIES(MAX_TRIES),
      .LONG_LOCK(LONG_LOCK), .SHORT_LOCK(SHORT_LOCK)
   ) dut (
      .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1), .SW(SW),
      .state_o(state_o), .acct_o(acct_o), .balance_o(balance_o), .tries_o(tries_o),
      .locked_o(locked_o), .err_o(err_o)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] acct;
      logic [7:0] bal;
      logic [1:0] tries;
      logic       locked;
      logic       err;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: account files, current screen, and remaining lock cycles.
   int   m_state, m_acct, m_tries, m_left, m_exit;
   bit   m_err;
   int   m_pw  [N_ACC];
   int   m_bal [N_ACC];

   function automatic obs_t model_obs();
      obs_t o;
      o.st     = 3'(m_state);
      o.acct   = 2'(m_acct);
      o.bal    = 8'(m_bal[m_acct]);
      o.tries  = 2'(m_tries);
      o.locked = (m_state == ST_LOCK);
      o.err    = m_err;
      return o;
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE; m_acct = 0; m_tries = 0; m_left = 0; m_exit = ST_IDLE; m_err = 0;
      for (int i = 0; i < N_ACC; i++) begin
         m_pw[i]  = 0;
         m_bal[i] = 0;
      end
   endtask

   task automatic start_lock(int cycles, int target);
      m_state = ST_LOCK;
      m_left  = cycles;
      m_exit  = target;
   endtask

   task automatic wrong_pw();
      m_tries++;
      if (m_tries >= MAX_TRIES) begin
         m_tries = 0;
         start_lock(LONG_LOCK, ST_IDLE);
      end
   endtask

   task automatic model_step(bit b3, bit b2, bit b1, int sw);
      int nb;
      nb    = int'(b3) + int'(b2) + int'(b1);
      m_err = 0;
      if (m_state == ST_LOCK) begin
         m_left--;
         if (m_left == 0) m_state = m_exit;
      end else if (nb == 1) begin
         case (m_state)
            ST_IDLE:
               if (b3) begin
                  if (sw >= N_ACC) m_err = 1;
                  else begin m_acct = sw; m_tries = 0; m_state = ST_PW_ENTRY; end
               end
            ST_PW_ENTRY:
               if (b3) begin
                  if (sw == m_pw[m_acct]) begin m_tries = 0; m_state = ST_MENU; end
                  else wrong_pw();
               end else if (b1) m_state = ST_IDLE;
            ST_MENU:
               if (b3) m_state = ST_MONEY;
               else if (b2) begin m_tries = 0; m_state = ST_PW_OLD; end
               else m_state = ST_IDLE;
            ST_MONEY:
               if (b3) begin
                  if (m_bal[m_acct] + sw > BAL_MAX) m_err = 1;
                  else m_bal[m_acct] += sw;
               end else if (b2) begin
                  if (sw <= m_bal[m_acct]) m_bal[m_acct] -= sw;
                  else begin m_err = 1; start_lock(SHORT_LOCK, ST_MONEY); end
               end else m_state = ST_MENU;
            ST_PW_OLD:
               if (b3) begin
                  if (sw == m_pw[m_acct]) begin m_tries = 0; m_state = ST_PW_NEW; end
                  else wrong_pw();
               end else if (b1) m_state = ST_MENU;
            ST_PW_NEW:
               if (b3) begin m_pw[m_acct] = sw; m_state = ST_MENU; end
               else if (b1) m_state = ST_MENU;
            default: m_state = ST_IDLE;
         endcase
      end
   endtask

   // Driver: one call = one cycle of inputs; expected post-edge outputs go to the scoreboard.
   task automatic press(bit b3, bit b2, bit b1, logic [3:0] sw);
      @(negedge clk);
      BTN3 = b3; BTN2 = b2; BTN1 = b1; SW = sw;
      model_step(b3, b2, b1, int'(sw));
      exp_q.push_back(model_obs());
   endtask

   task automatic idle(int n);
      repeat (n) press(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
   endtask

   function automatic obs_t dut_obs();
      return {state_o, acct_o, balance_o, tries_o, locked_o, err_o};
   endfunction

   task automatic check_now(string name);
      obs_t a, e;
      a = dut_obs();
      e = model_obs();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got st=%0d acct=%0d bal=%0d tries=%0d lock=%0d err=%0d want st=%0d acct=%0d bal=%0d tries=%0d lock=%0d err=%0d",
                  name, a.st, a.acct, a.bal, a.tries, a.locked, a.err,
                  e.st, e.acct, e.bal, e.tries, e.locked, e.err);
      end
   endtask

   task automatic reset_now();
      @(negedge clk);
      BTN3 = 1'b0; BTN2 = 1'b0; BTN1 = 1'b0;
      #1 rst = 1'b0;
      model_reset();
      #1 check_now("async_reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Monitor: pops one expectation per clock and compares all outputs.
   initial begin
      obs_t a, e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_obs();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle@%0t got st=%0d acct=%0d bal=%0d tries=%0d lock=%0d err=%0d want st=%0d acct=%0d bal=%0d tries=%0d lock=%0d err=%0d",
                        $time, a.st, a.acct, a.bal, a.tries, a.locked, a.err,
                        e.st, e.acct, e.bal, e.tries, e.locked, e.err);
            end
         end
      end
   end

   initial begin
      int r;
      bit b3, b2, b1;
      logic [3:0] sw;
      rst = 1'b0; BTN3 = 1'b0; BTN2 = 1'b0; BTN1 = 1'b0; SW = '0;
      model_reset();
      #3 check_now("reset_state");
      @(negedge clk);
      rst = 1'b1;

      // Account 1: log in with default password, deposit 5, change password to 9, log out.
      press(1,0,0,1); press(1,0,0,0); press(1,0,0,0); press(1,0,0,5);
      press(0,0,1,0); press(0,1,0,0); press(1,0,0,0); press(1,0,0,9);
      press(0,0,1,0);
      // Three wrong passwords -> long lock, then log in with 9.
      press(1,0,0,1); press(1,0,0,0); press(1,0,0,4); press(1,0,0,2);
      idle(LONG_LOCK + 5);
      press(1,0,0,1); press(1,0,0,9); press(1,0,0,0);
      // Withdraw 4, overdraw 2 -> short lock; BTN1 during lock ignored.
      press(0,1,0,4); press(0,1,0,2); press(0,0,1,0); idle(5); press(0,0,1,0);
      idle(SHORT_LOCK);
      press(0,1,0,1); press(0,1,0,0); press(1,0,0,0);
      // Password-change path: three wrong current passwords.
      press(0,0,1,0); press(0,1,0,0); press(1,0,0,1); press(1,0,0,2); press(1,0,0,3);
      idle(LONG_LOCK + 5);
      // Account 2 to 250, then overflowing deposit.
      press(1,0,0,2); press(1,0,0,0); press(1,0,0,0);
      repeat (16) press(1,0,0,15);
      press(1,0,0,10); press(1,0,0,15); press(1,0,0,6); press(0,1,0,0);
      // Multi-button in MENU, invalid account, account 0 untouched.
      press(0,0,1,0); press(1,0,1,0); press(0,1,1,0); press(0,0,1,0);
      press(1,0,0,7); press(1,0,0,0); press(1,0,0,0); press(1,0,0,0);
      press(0,1,0,1); idle(10);
      reset_now();
      press(1,0,0,1); press(1,0,0,0); press(1,0,0,0); idle(2);
      press(0,0,1,0); press(0,0,1,0);
      press(1,0,0,2); press(1,0,0,0); press(1,0,0,0); idle(2);

      // Random traffic, biased toward single presses and small switch values.
      for (int i = 0; i < 3000; i++) begin
         r  = int'($urandom_range(0, 99));
         b3 = 0; b2 = 0; b1 = 0;
         if (r < 55) begin
            case ($urandom_range(0, 2))
               0: b3 = 1;
               1: b2 = 1;
               default: b1 = 1;
            endcase
         end else if (r >= 88) begin
            b3 = 1'($urandom_range(0, 1)); b2 = 1; b1 = 1'($urandom_range(0, 1));
         end
         sw = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         press(b3, b2, b1, sw);
      end
      idle(1);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
